fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end. It replaces the combinational PC/PC+4/next-PC mux path of the single-cycle core with a sequential fetch stage.
- Issues in-order requests to an instruction memory that has wait states. Buffers returned instructions in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts taken-branch/jump redirects from the execute stage and discards all stale in-flight fetches.

Parameters:
- XLEN, 32, address/PC width.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2. Also the maximum number of outstanding plus buffered fetches.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- halt  in  1  stops issue of new requests; the FIFO still fills and drains.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response beat; in order, no backpressure, latency >= 1 cycle.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken (NextPcSrc).
- redirect_target  in  XLEN  new PC (ALU result).
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode consumes head.
- inst  out  32  head instruction.
- inst_pc  out  XLEN  PC of head.
- inst_pc_plus4  out  XLEN  inst_pc + 4, for the JAL/JALR link write.

Behaviour:
Reset (async assert, sync deassert internally):
- fetch_pc = RESET_VECTOR; FSM = S_BOOT.
- imem_req_valid = 0, inst_valid = 0; inst, inst_pc, inst_pc_plus4 = 0.
- outstanding = 0, drop count = 0, FIFO empty.
- Reset mid-operation discards everything. Responses arriving after reset deassert for pre-reset requests are not tracked; the memory is reset together with this block.

FSM:
- S_BOOT: one idle cycle after reset deasserts, then -> S_FETCH.
- S_FETCH: issue requests. -> S_HALT when halt=1 and no request is pending.
- S_HALT: no new requests. -> S_FETCH when halt=0.
- redirect_valid is honoured in every state except S_BOOT, where it is ignored.

Issue:
- imem_req_valid = 1 in S_FETCH when credit is available: (outstanding + fifo_count) < FIFO_DEPTH, all counters width $clog2(FIFO_DEPTH)+1.
- imem_req_addr = fetch_pc.
- Once valid is asserted, addr and valid stay stable until ready, unless a redirect occurs.
- On handshake: fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding += 1.
- No combinational path from imem_req_ready to imem_req_valid.

Response:
- Each imem_rsp_valid decrements outstanding.
- If drop count > 0, decrement it and discard the beat.
- Otherwise push {data, pc} into the FIFO. pc is tracked by a separate rsp_pc register that increments by 4 per accepted beat.
- The FIFO can never overflow because of the credit rule.

Pop:
- inst_valid = !empty. The head is registered, so there is no combinational path from input to output.
- Handshake (inst_valid & inst_ready) pops one entry.
- Push and pop in the same cycle leave the count unchanged.
- Throughput: 1 instruction/cycle when the memory sustains it.

Redirect (highest priority):
- In the cycle redirect_valid = 1:
  - FIFO flushed; inst_valid = 0 next cycle. A pop in the same cycle is ignored.
  - drop count = outstanding after this cycle's events: an accepted request adds 1, a response beat this cycle subtracts 1.
  - fetch_pc = rsp_pc = {redirect_target[XLEN-1:2], 2'b00}; misaligned low bits are forced to zero.
  - A pending unaccepted request is withdrawn; the new address is presented the next cycle.
- Redirect and reset assert together: reset wins.
- Back-to-back redirects: the latest target wins and drop count is recomputed each time.

Decomposition:
- Package fetch_pkg:
  - typedef enum fetch_state_t {S_BOOT, S_FETCH, S_HALT}.
  - typedef struct fetch_entry_t {logic [31:0] inst; logic [XLEN-1:0] pc;}, with XLEN taken from a package localparam defaulting to 32.
  - constant NOP_INST = 32'h0000_0013.
- Sub-module fetch_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/flush/full/empty/count, asynchronous active-high reset. fetch_unit instantiates it once.

Test Plan:
- Credit limit: RESET_VECTOR=32'h100, FIFO_DEPTH=4, req_ready=1, 1-cycle memory, inst_ready=0 -> exactly 4 requests (0x100, 0x104, 0x108, 0x10C), then imem_req_valid=0. inst_valid=1 with inst_pc=0x100.
- Streaming: inst_ready=1, 1-cycle memory -> in steady state one instruction per cycle; inst_pc increments by 4 and inst_pc_plus4 = inst_pc+4 each beat (e.g. 0x10C -> 0x110).
- Redirect: 2 requests in flight, memory latency 3, redirect_target=32'h200 -> both responses dropped; next request addr 0x200; first inst_valid beat has inst_pc=0x200.
- Request stall: imem_req_ready=0 for 3 cycles -> imem_req_valid and imem_req_addr=0x104 held stable. Misaligned redirect target 0x203 -> next request addr 0x200.
- Halt: halt=1 mid-stream -> no new requests after the pending one completes; buffered instructions still drain. halt=0 -> resumes at the next sequential address.
- Reset mid-operation: rst pulses high while FIFO holds 3 entries -> inst_valid=0 and imem_req_valid=0 immediately. After release, one S_BOOT cycle, then a request to RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instruction, pc} entries.
// The head is read straight from registered storage, so there is no
// combinational path from push data to the head output.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: storage has no reset; count/empty decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction-fetch stage: credit-limited in-order requests to a
// wait-state instruction memory, response buffering, valid/ready hand-off to
// decode, and redirect handling that discards every stale in-flight fetch.
module fetch_unit import fetch_pkg::*; #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_plus4
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 32 + XLEN;

  logic            rst_i;
  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_use;
  logic            req_fire;
  logic            redir;
  logic            rsp_accept;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [XLEN-1:0] redir_pc;
  logic [EW-1:0]   head;
  logic            unused_target_lsbs;

  // Reset asserts asynchronously and is released on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_i <= 1'b1;
    else     rst_i <= 1'b0;
  end

  // Credit: every in-flight request and buffered entry owns one FIFO slot.
  assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = (state == S_FETCH) && (in_use < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Redirects are ignored during the boot cycle.
  assign redir              = redirect_valid && (state != S_BOOT);
  assign redir_pc           = {redirect_target[XLEN-1:2], 2'b00};
  assign unused_target_lsbs = ^redirect_target[1:0];

  // Beats arriving with nothing outstanding belong to pre-reset traffic.
  assign rsp_accept = imem_rsp_valid && (outstanding != '0) && (drop_cnt == '0) && !redir;
  assign fifo_push  = rsp_accept && !fifo_full;
  assign fifo_pop   = inst_valid && inst_ready && !redir;

  // In-flight count after this cycle's request and response events.
  // NOTE: blocking '=' in always_comb, '<=' for every flop; the leading default avoids a latch.
  always_comb begin
    outstanding_nxt = outstanding;
    if (imem_rsp_valid && (outstanding != '0)) outstanding_nxt = outstanding_nxt - CW'(1);
    if (req_fire)                              outstanding_nxt = outstanding_nxt + CW'(1);
  end

  // Control FSM: one idle boot cycle, then fetch until halted.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state <= S_BOOT;
    end else begin
      case (state)
        S_BOOT:  state <= S_FETCH;
        S_FETCH: if (halt && (!imem_req_valid || imem_req_ready)) state <= S_HALT;
        S_HALT:  if (!halt) state <= S_FETCH;
        default: state <= S_BOOT;
      endcase
    end
  end

  // Fetch/response PCs and in-flight bookkeeping; redirect overrides everything.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_VECTOR;
      rsp_pc      <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redir) begin
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (req_fire)   fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_accept) rsp_pc   <= rsp_pc + XLEN'(4);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst_i),
    .push     (fifo_push),
    .push_data({imem_rsp_data, rsp_pc}),
    .pop      (fifo_pop),
    .flush    (redir),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign inst_valid    = !fifo_empty;
  assign inst          = inst_valid ? head[EW-1:XLEN] : 32'h0;
  assign inst_pc       = inst_valid ? head[XLEN-1:0] : '0;
  assign inst_pc_plus4 = inst_valid ? head[XLEN-1:0] + XLEN'(4) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural instruction memory, a
// program-order reference model, directed corner sequences and random traffic.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, halt, inst_ready, redirect_valid;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, inst_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_target;
  logic [31:0] inst, inst_pc, inst_pc_plus4;
  logic        man_ready, rnd_ready;
  bit          rand_ready = 1'b0;
  bit          rand_lat   = 1'b0;
  int          lat        = 1;
  int          checks     = 0;
  int          failures   = 0;
  int          cyc        = 0;
  int          req_count  = 0;
  int          pops       = 0;

  always #5 clk = ~clk;

  assign imem_req_ready = rand_ready ? rnd_ready : man_ready;

  fetch_unit #(.XLEN(32), .RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .halt           (halt),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc_plus4  (inst_pc_plus4)
  );

  // Instruction word stored at each address of the behavioural memory.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {16'h5A5A, NOP_INST[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Instruction memory: in-order responses, per-request latency >= 1.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  initial begin
    mreq_t r;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    rnd_ready      = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mq.delete();
      end else begin
        if (imem_rsp_valid) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready) begin
          r.addr = imem_req_addr;
          r.due  = cyc + (rand_lat ? int'($urandom_range(4, 1)) : lat);
          mq.push_back(r);
        end
      end
      #1;
      rnd_ready = ($urandom_range(3, 0) != 0);
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mq[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Reference model: requests and delivered instructions follow program order,
  // restarting at the word-aligned target on every redirect.
  logic [31:0] exp_req = RV;
  logic [31:0] exp_pc  = RV;
  logic        pv = 1'b0, pr = 1'b0, pred = 1'b0, prst = 1'b1;
  logic [31:0] pa = 32'h0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_req   = RV;
        exp_pc    = RV;
        req_count = 0;
        prst      = 1'b1;
      end else begin
        if (!prst && pv && !pr && !pred) begin
          check("req_hold_valid", 32'(imem_req_valid), 32'd1);
          check("req_hold_addr", imem_req_addr, pa);
        end
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", imem_req_addr, exp_req);
          exp_req = exp_req + 32'd4;
          req_count++;
        end
        if (redirect_valid) begin
          exp_req = {redirect_target[31:2], 2'b00};
          exp_pc  = {redirect_target[31:2], 2'b00};
        end else if (inst_valid && inst_ready) begin
          check("pop_pc", inst_pc, exp_pc);
          check("pop_inst", inst, mem_word(exp_pc));
          check("pop_pc_plus4", inst_pc_plus4, exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
        prst = 1'b0;
      end
      pv   = imem_req_valid;
      pr   = imem_req_ready;
      pred = redirect_valid;
      pa   = imem_req_addr;
    end
  end

  task automatic pulse_redirect(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    step(1);
    redirect_valid  = 1'b0;
  endtask

  task automatic wait_req_valid(input string name);
    int n;
    n = 0;
    while (!imem_req_valid && n < 30) begin
      step(1);
      n++;
    end
    check(name, 32'(imem_req_valid), 32'd1);
  endtask

  task automatic wait_inst_valid(input string name);
    int n;
    n = 0;
    while (!inst_valid && n < 30) begin
      step(1);
      n++;
    end
    check(name, 32'(inst_valid), 32'd1);
  endtask

  // Hold reset, release it and confirm one idle boot cycle before fetching RV.
  task automatic reset_and_boot();
    int idle;
    rst = 1'b1;
    step(3);
    rst  = 1'b0;
    idle = 0;
    step(1);
    while (!imem_req_valid && idle < 10) begin
      idle++;
      step(1);
    end
    check("boot_idle_cycles", 32'(idle), 32'd1);
    check("boot_req_valid", 32'(imem_req_valid), 32'd1);
    check("boot_req_addr", imem_req_addr, RV);
  endtask

  typedef struct {
    logic [31:0] target;
    logic [31:0] addr;
    logic [31:0] pc4;
  } vec_t;

  initial begin
    vec_t vt[5];
    int   p0;
    int   r0;
    int   n;
    logic [31:0] e;

    vt[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
    vt[1] = '{32'h0000_0400, 32'h0000_0400, 32'h0000_0404};
    vt[2] = '{32'h0000_07FF, 32'h0000_07FC, 32'h0000_0800};
    vt[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[4] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004};

    rst = 1'b0; halt = 1'b0; man_ready = 1'b1; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    #1 rst = 1'b1;
    #2;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_pc_plus4", inst_pc_plus4, 32'h0);

    reset_and_boot();

    // Request stall: first request accepted, second held for three cycles.
    step(1);
    man_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(imem_req_valid), 32'd1);
      check("stall_addr", imem_req_addr, 32'h104);
      step(1);
    end
    man_ready = 1'b1;

    // Credit limit with decode stalled.
    step(10);
    check("credit_req_count", 32'(req_count), 32'd4);
    check("credit_req_valid", 32'(imem_req_valid), 32'd0);
    check("credit_inst_valid", 32'(inst_valid), 32'd1);
    check("credit_head_pc", inst_pc, 32'h100);
    check("credit_head_inst", inst, mem_word(32'h100));

    // Streaming at one instruction per cycle.
    inst_ready = 1'b1;
    step(8);
    p0 = pops;
    step(16);
    check("stream_rate", 32'(pops - p0), 32'd16);

    // Redirect with latency-3 memory and requests in flight.
    lat = 3;
    step(6);
    n = 0;
    while (mq.size() < 2 && n < 30) begin
      step(1);
      n++;
    end
    check("redir_inflight_ge2", 32'(mq.size() >= 2), 32'd1);
    pulse_redirect(32'h200);
    wait_req_valid("redir_req_valid");
    check("redir_req_addr", imem_req_addr, 32'h200);
    wait_inst_valid("redir_inst_valid");
    check("redir_first_pc", inst_pc, 32'h200);
    check("redir_first_inst", inst, mem_word(32'h200));

    // Redirect alignment table.
    lat = 1;
    step(4);
    for (int i = 0; i < 5; i++) begin
      pulse_redirect(vt[i].target);
      wait_req_valid("vec_req_valid");
      check("vec_req_addr", imem_req_addr, vt[i].addr);
      wait_inst_valid("vec_inst_valid");
      check("vec_inst_pc", inst_pc, vt[i].addr);
      check("vec_inst_pc_plus4", inst_pc_plus4, vt[i].pc4);
      step(4);
    end

    // Halt: no new requests, buffer drains, resume sequentially.
    halt = 1'b1;
    step(3);
    r0 = req_count;
    step(10);
    check("halt_no_new_req", 32'(req_count), 32'(r0));
    check("halt_req_valid", 32'(imem_req_valid), 32'd0);
    check("halt_drained", 32'(inst_valid), 32'd0);
    e = exp_req;
    halt = 1'b0;
    wait_req_valid("resume_req_valid");
    check("resume_addr", imem_req_addr, e);

    // Random traffic against the reference model.
    rand_ready = 1'b1;
    rand_lat   = 1'b1;
    p0 = pops;
    for (int i = 0; i < 2000; i++) begin
      inst_ready = ($urandom_range(3, 0) != 0);
      halt       = halt ^ ($urandom_range(31, 0) == 0);
      if ($urandom_range(19, 0) == 0) begin
        redirect_valid  = 1'b1;
        redirect_target = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                      : $urandom;
      end else begin
        redirect_valid = 1'b0;
      end
      step(1);
    end
    redirect_valid = 1'b0; halt = 1'b0; rand_ready = 1'b0; rand_lat = 1'b0;
    inst_ready = 1'b1;
    step(20);
    check("random_progress", 32'(pops - p0 > 100), 32'd1);

    // Reset mid-operation with three buffered entries.
    inst_ready = 1'b0;
    man_ready  = 1'b0;
    pulse_redirect(32'h300);
    step(6);
    r0 = req_count;
    man_ready = 1'b1;
    n = 0;
    while (req_count < r0 + 3 && n < 30) begin
      step(1);
      n++;
    end
    step(2);
    check("pre_rst_inst_valid", 32'(inst_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_mid_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_mid_inst_pc", inst_pc, 32'h0);
    reset_and_boot();
    inst_ready = 1'b1;
    wait_inst_valid("post_rst_inst_valid");
    check("post_rst_first_pc", inst_pc, RV);
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
